delta_pe_array: RTL

Parametrised multi-lane successor of the single delta processing element. It holds LANES independent signed accumulators that share one command stream. Each accumulator is either loaded with a full product (input × weight) or updated with a delta term (input << delta). Results are emitted through a registered valid/ready output port with backpressure. It sits between the delta-encoded weight fetch stage and the output write-back buffer.

---
 rtl/delta_pe_array.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/delta_pe_array.sv
`default_nettype none
// delta_pe_array: LANES signed accumulators sharing one MULT/DELTA/CLEAR/FLUSH command stream,
// results emitted on a registered valid/ready port. Define DELTA_PE_SATURATE_EN to clamp DELTA sums.
// Revision: 1.0
module delta_pe_array #(
    parameter int LANES       = 4,
    parameter int BIN_LEN     = 8,
    parameter int DELTA_LEN   = 4,
    parameter int OUT_BIN_LEN = 24
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_in_valid,
    output logic                           o_in_ready,
    input  logic [1:0]                     i_in_op,
    input  logic [LANES-1:0]               i_lane_en,
    input  logic [LANES*BIN_LEN-1:0]       i_input_val,
    input  logic [LANES*BIN_LEN-1:0]       i_weight_val,
    input  logic [LANES*DELTA_LEN-1:0]     i_delta_val,
    output logic                           o_out_valid,
    input  logic                           i_out_ready,
    output logic [LANES*OUT_BIN_LEN-1:0]   o_out_vals,
    output logic [7:0]                     o_op_count,
    output logic [LANES-1:0]               o_overflow
);

    localparam int c_PROD_LEN = 2 * BIN_LEN;
    localparam int c_TERM_LEN = OUT_BIN_LEN + 2**DELTA_LEN - 1;
    localparam int c_SUM_LEN  = c_TERM_LEN + 1;

    localparam logic [1:0] c_OP_MULT  = 2'd0;
    localparam logic [1:0] c_OP_DELTA = 2'd1;
    localparam logic [1:0] c_OP_CLEAR = 2'd2;
    localparam logic [1:0] c_OP_FLUSH = 2'd3;

    typedef enum logic [0:0] {
        S_EMPTY  = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t                               r_state;
    logic [LANES-1:0][OUT_BIN_LEN-1:0]    r_acc;
    logic [LANES-1:0][OUT_BIN_LEN-1:0]    r_out_vals;
    logic                                 r_out_valid;
    logic [7:0]                           r_op_count;
    logic [LANES-1:0]                     r_overflow;

    logic [LANES-1:0][OUT_BIN_LEN-1:0]    w_mult_acc;
    logic [LANES-1:0][OUT_BIN_LEN-1:0]    w_delta_acc;
    logic [LANES-1:0]                     w_delta_ovf;
    logic                                 w_accept;

    assign o_in_ready  = !r_out_valid || i_out_ready;
    assign w_accept    = i_in_valid && o_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_vals  = r_out_vals;
    assign o_op_count  = r_op_count;
    assign o_overflow  = r_overflow;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [BIN_LEN-1:0]    w_in;
            logic signed [BIN_LEN-1:0]    w_wt;
            logic        [DELTA_LEN-1:0]  w_sh;
            logic signed [c_PROD_LEN-1:0] w_prod;
            logic signed [c_TERM_LEN-1:0] w_term;
            logic signed [c_SUM_LEN-1:0]  w_sum;
            logic                         w_fits;

            assign w_in   = $signed(i_input_val[gi*BIN_LEN +: BIN_LEN]);
            assign w_wt   = $signed(i_weight_val[gi*BIN_LEN +: BIN_LEN]);
            assign w_sh   = i_delta_val[gi*DELTA_LEN +: DELTA_LEN];
            assign w_prod = c_PROD_LEN'(w_in) * c_PROD_LEN'(w_wt);
            assign w_term = c_TERM_LEN'(w_in) <<< w_sh;
            assign w_sum  = c_SUM_LEN'($signed(r_acc[gi])) + c_SUM_LEN'(w_term);
            // The sum fits when every bit above the output sign bit copies it.
            assign w_fits = (&w_sum[c_SUM_LEN-1:OUT_BIN_LEN-1]) | ~(|w_sum[c_SUM_LEN-1:OUT_BIN_LEN-1]);

            assign w_mult_acc[gi]  = OUT_BIN_LEN'(w_prod);
            assign w_delta_ovf[gi] = ~w_fits;
`ifdef DELTA_PE_SATURATE_EN
            localparam logic [OUT_BIN_LEN-1:0] c_ACC_MAX = {1'b0, {(OUT_BIN_LEN-1){1'b1}}};
            localparam logic [OUT_BIN_LEN-1:0] c_ACC_MIN = {1'b1, {(OUT_BIN_LEN-1){1'b0}}};
            assign w_delta_acc[gi] = w_fits ? w_sum[OUT_BIN_LEN-1:0]
                                   : (w_sum[c_SUM_LEN-1] ? c_ACC_MIN : c_ACC_MAX);
`else
            assign w_delta_acc[gi] = w_sum[OUT_BIN_LEN-1:0];
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_acc       <= '0;
            r_out_vals  <= '0;
            r_out_valid <= 1'b0;
            r_op_count  <= 8'd0;
            r_overflow  <= '0;
        end else begin
            if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                case (i_in_op)
                    c_OP_MULT: begin
                        for (int l = 0; l < LANES; l++) begin
                            if (i_lane_en[l]) r_acc[l] <= w_mult_acc[l];
                        end
                        r_op_count <= 8'd1;
                        r_state    <= S_ACTIVE;
                    end
                    c_OP_DELTA: begin
                        for (int l = 0; l < LANES; l++) begin
                            if (i_lane_en[l]) begin
                                r_acc[l] <= w_delta_acc[l];
                                if (w_delta_ovf[l]) r_overflow[l] <= 1'b1;
                            end
                        end
                        if (r_op_count != 8'hFF) r_op_count <= r_op_count + 8'd1;
                        r_state <= S_ACTIVE;
                    end
                    c_OP_CLEAR: begin
                        for (int l = 0; l < LANES; l++) begin
                            if (i_lane_en[l]) begin
                                r_acc[l]      <= '0;
                                r_overflow[l] <= 1'b0;
                            end
                        end
                        r_op_count <= 8'd0;
                        // A partial clear leaves other lanes possibly non-zero.
                        if (&i_lane_en) r_state <= S_EMPTY;
                    end
                    default: begin
                        r_out_vals  <= r_acc;
                        r_out_valid <= 1'b1;
                        r_acc       <= '0;
                        r_overflow  <= '0;
                        r_op_count  <= 8'd0;
                        r_state     <= S_EMPTY;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
